// File: rtl/alu_4b_operand_seq_if.sv
// Bus between the operand sequencer, the switch/strobe front end and alu_4b.
// The slave modport is the sequencer's view; master is the surrounding board logic.
interface alu_4b_operand_seq_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic [W-1:0]     data_in;
    logic             load;
    logic [W-1:0]     alu_result;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [W-1:0]     alu_opcode;
    logic [W-1:0]     result_q;
    logic             valid;
    logic             err;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] op_count;

    modport master (
        output data_in, load, alu_result,
        input  alu_a, alu_b, alu_opcode, result_q, valid, err, state_o, op_count
    );

    modport slave (
        input  data_in, load, alu_result,
        output alu_a, alu_b, alu_opcode, result_q, valid, err, state_o, op_count
    );
endinterface

// File: rtl/alu_4b_operand_seq.sv
// Collects A, B and opcode from a shared switch bus, runs one execute cycle on alu_4b,
// latches the result and counts operations. Define ACC_CHAIN_EN for accumulator chaining.
module alu_4b_operand_seq #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_4b_operand_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_EXEC = 2'b11
    } state_t;

    state_t           state, state_nx;
    logic [W-1:0]     a_q, a_nx;
    logic [W-1:0]     b_q, b_nx;
    logic [W-1:0]     op_q, op_nx;
    logic [W-1:0]     res_q, res_nx;
    logic             valid_q, valid_nx;
    logic             err_q, err_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             op_legal;

    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            4'b0001, 4'b0010, 4'b0011,
            4'b0101, 4'b0110,
            4'b1001, 4'b1010,
            4'b1101, 4'b1110: op_legal = 1'b1;
            default:          op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            op_q    <= op_nx;
            res_q   <= res_nx;
            valid_q <= valid_nx;
            err_q   <= err_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // Everything holds unless the current state consumes a load or finishes the execute cycle.
    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        op_nx    = op_q;
        res_nx   = res_q;
        valid_nx = valid_q;
        err_nx   = err_q;
        cnt_nx   = cnt_q;
        case (state)
            S_A: begin
                if (bus.load) begin
`ifdef ACC_CHAIN_EN
                    if (valid_q && !err_q) begin
                        a_nx     = res_q;
                        b_nx     = bus.data_in;
                        valid_nx = 1'b0;
                        state_nx = S_OP;
                    end else begin
                        a_nx     = bus.data_in;
                        valid_nx = 1'b0;
                        err_nx   = 1'b0;
                        state_nx = S_B;
                    end
`else
                    a_nx     = bus.data_in;
                    valid_nx = 1'b0;
                    err_nx   = 1'b0;
                    state_nx = S_B;
`endif
                end
            end
            S_B: begin
                if (bus.load) begin
                    b_nx     = bus.data_in;
                    state_nx = S_OP;
                end
            end
            S_OP: begin
                if (bus.load) begin
                    op_nx    = bus.data_in;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                res_nx   = op_legal ? bus.alu_result : '0;
                err_nx   = !op_legal;
                valid_nx = 1'b1;
                cnt_nx   = cnt_q + CNT_W'(1);
                state_nx = S_A;
            end
            default: state_nx = S_A;
        endcase
    end

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_opcode = op_q;
    assign bus.result_q   = res_q;
    assign bus.valid      = valid_q;
    assign bus.err        = err_q;
    assign bus.state_o    = state;
    assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_alu_4b_operand_seq.sv
// Bench for alu_4b_operand_seq with an in-bench alu_4b stand-in and a cycle-level reference model.
// Build with +define+ACC_CHAIN_EN to exercise accumulator chaining expectations.
module tb_alu_4b_operand_seq;
    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu_4b_operand_seq_if #(.W(W), .CNT_W(CNT_W)) bus ();

    alu_4b_operand_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for alu_4b; illegal codes return all ones so a missing clear is visible.
    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        case (op)
            4'b0001: return a & b;
            4'b0010: return a | b;
            4'b0011: return a ^ b;
            4'b0101: return a + b;
            4'b0110: return a - b;
            4'b1001: return (a < b) ? 4'd1 : 4'd0;
            4'b1010: return (a == b) ? 4'd1 : 4'd0;
            4'b1101: return a >> 1;
            4'b1110: return a << 1;
            default: return 4'b1111;
        endcase
    endfunction

    always_comb bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_opcode);

    logic [3:0] legal_ops [9] = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                                  4'b1001, 4'b1010, 4'b1101, 4'b1110};
    logic [1:0] phase_code [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    // Reference model: phase 0 waits for A, 1 for B, 2 for opcode, 3 is the execute cycle.
    int         m_phase;
    logic [3:0] m_a, m_b, m_op, m_res;
    logic       m_valid, m_err;
    int         m_cnt;

    function automatic bit is_legal(input logic [3:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic ld, input logic [3:0] d, input logic r);
        bit chain;
        if (r) begin
            m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
            m_valid = 0; m_err = 0; m_cnt = 0;
            return;
        end
`ifdef ACC_CHAIN_EN
        chain = m_valid && !m_err;
`else
        chain = 1'b0;
`endif
        if (m_phase == 3) begin
            m_err   = !is_legal(m_op);
            m_res   = m_err ? 4'b0000 : alu_ref(m_a, m_b, m_op);
            m_valid = 1'b1;
            m_cnt   = (m_cnt + 1) % 256;
            m_phase = 0;
        end else if (ld) begin
            if (m_phase == 0 && chain) begin
                m_a = m_res; m_b = d; m_valid = 0; m_phase = 2;
            end else if (m_phase == 0) begin
                m_a = d; m_valid = 0; m_err = 0; m_phase = 1;
            end else if (m_phase == 1) begin
                m_b = d; m_phase = 2;
            end else begin
                m_op = d; m_phase = 3;
            end
        end
    endtask

    // One clock: drive at a falling edge, let the rising edge pass, sample at the next falling edge.
    task automatic applyStimulus(input logic ld, input logic [3:0] d, input logic r);
        bus.load    = ld;
        bus.data_in = d;
        rst         = r;
        model_step(ld, d, r);
        @(negedge clk);
        bus.load = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        applyStimulus(1'b1, a, 1'b0);
        applyStimulus(1'b1, b, 1'b0);
        applyStimulus(1'b1, op, 1'b0);
    endtask

    task automatic test_reset();
        logic [34:0] got, exp;
        applyStimulus(1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1);
        got = {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.result_q, bus.valid, bus.err, bus.state_o, bus.op_count, 7'd0};
        exp = '0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_state got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_and();
        run_op(4'b1010, 4'b1100, 4'b0001);
        applyStimulus(1'b0, 4'h0, 1'b0);
        checks++;
        if (bus.result_q !== 4'b1000) begin errors++; $display("[TB] FAIL and_result got=%b exp=1000", bus.result_q); end
        checks++;
        if ({bus.valid, bus.err} !== 2'b10) begin errors++; $display("[TB] FAIL and_flags got=%b exp=10", {bus.valid, bus.err}); end
        checks++;
        if (bus.op_count !== 8'd1) begin errors++; $display("[TB] FAIL and_count got=%0d exp=1", bus.op_count); end
        checks++;
        if (bus.state_o !== 2'b00) begin errors++; $display("[TB] FAIL and_state got=%b exp=00", bus.state_o); end
    endtask

    task automatic test_sub_exec_load();
        run_op(4'b1001, 4'b0010, 4'b0110);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        checks++;
        if (bus.result_q !== 4'b0111) begin errors++; $display("[TB] FAIL sub_result got=%b exp=0111", bus.result_q); end
        checks++;
        if (bus.state_o !== 2'b00 || bus.alu_a !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL sub_exec_load_ignored got state=%b a=%b exp state=00 a=1001", bus.state_o, bus.alu_a);
        end
        checks++;
        if (bus.op_count !== 8'd2) begin errors++; $display("[TB] FAIL sub_count got=%0d exp=2", bus.op_count); end
    endtask

    task automatic test_illegal();
        run_op(4'b0011, 4'b0001, 4'b0100);
        applyStimulus(1'b0, 4'h0, 1'b0);
        checks++;
        if ({bus.result_q, bus.valid, bus.err} !== 6'b0000_11) begin
            errors++;
            $display("[TB] FAIL illegal_result got=%b/%b/%b exp=0000/1/1", bus.result_q, bus.valid, bus.err);
        end
        checks++;
        if (bus.op_count !== 8'd3) begin errors++; $display("[TB] FAIL illegal_count got=%0d exp=3", bus.op_count); end
        applyStimulus(1'b0, 4'h0, 1'b0);
        checks++;
        if ({bus.valid, bus.err} !== 2'b11) begin errors++; $display("[TB] FAIL illegal_persist got=%b exp=11", {bus.valid, bus.err}); end
        applyStimulus(1'b1, 4'b0111, 1'b0);
        checks++;
        if ({bus.valid, bus.err, bus.state_o, bus.alu_a} !== 8'b0_0_01_0111) begin
            errors++;
            $display("[TB] FAIL illegal_clear got v=%b e=%b s=%b a=%b exp v=0 e=0 s=01 a=0111",
                     bus.valid, bus.err, bus.state_o, bus.alu_a);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b0, 4'h0, 1'b1);
        run_op(4'b0101, 4'b0011, 4'b0101);
        applyStimulus(1'b0, 4'h0, 1'b1);
        checks++;
        if ({bus.result_q, bus.valid, bus.op_count, bus.state_o} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_result got r=%b v=%b c=%0d s=%b exp all zero",
                     bus.result_q, bus.valid, bus.op_count, bus.state_o);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_operands got a=%b b=%b op=%b exp 0", bus.alu_a, bus.alu_b, bus.alu_opcode);
        end
    endtask

    task automatic test_wrap();
        applyStimulus(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            run_op(4'b1111, 4'b1111, 4'b1010);
            applyStimulus(1'b0, 4'h0, 1'b0);
            checks++;
            if (bus.result_q !== 4'b0001 || bus.op_count !== 8'((i + 1) % 256)) begin
                errors++;
                $display("[TB] FAIL wrap_op%0d got r=%b c=%0d exp r=0001 c=%0d", i, bus.result_q, bus.op_count, (i + 1) % 256);
            end
        end
    endtask

    task automatic test_chain();
        applyStimulus(1'b0, 4'h0, 1'b1);
        run_op(4'b0101, 4'b0011, 4'b0101);
        applyStimulus(1'b0, 4'h0, 1'b0);
        checks++;
        if (bus.result_q !== 4'b1000) begin errors++; $display("[TB] FAIL chain_add got=%b exp=1000", bus.result_q); end
        applyStimulus(1'b1, 4'b0001, 1'b0);
        applyStimulus(1'b1, 4'b0110, 1'b0);
`ifdef ACC_CHAIN_EN
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.state_o} !== 10'b1000_0001_11) begin
            errors++;
            $display("[TB] FAIL chain_operands got a=%b b=%b s=%b exp a=1000 b=0001 s=11", bus.alu_a, bus.alu_b, bus.state_o);
        end
        applyStimulus(1'b0, 4'h0, 1'b0);
        checks++;
        if (bus.result_q !== 4'b0111 || bus.valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL chain_result got r=%b v=%b exp r=0111 v=1", bus.result_q, bus.valid);
        end
`else
        checks++;
        if (bus.alu_a !== 4'b0001 || bus.state_o !== 2'b10) begin
            errors++;
            $display("[TB] FAIL nochain_state got a=%b s=%b exp a=0001 s=10", bus.alu_a, bus.state_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0]  d;
        logic        ld, r;
        logic [34:0] got, exp;
        applyStimulus(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 500; i++) begin
            ld = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 79) == 0);
            d  = 4'($urandom);
            if (m_phase == 2 && $urandom_range(0, 3) != 0) d = legal_ops[$urandom_range(0, 8)];
            applyStimulus(ld, d, r);
            got = {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.result_q, bus.valid, bus.err, bus.state_o, bus.op_count, 7'd0};
            exp = {m_a, m_b, m_op, m_res, m_valid, m_err, phase_code[m_phase], 8'(m_cnt), 7'd0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        bus.load    = 1'b0;
        bus.data_in = 4'h0;
        model_step(1'b0, 4'h0, 1'b1);
        @(negedge clk);
        test_reset();
        test_and();
        test_sub_exec_load();
        test_illegal();
        test_reset_mid();
        test_wrap();
        test_chain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
